// File: rtl/load_store_unit.sv
// Memory-stage load/store unit.
// Accepts one load or store from execute, runs a single req/ack memory
// transaction with an optional timeout, and returns extended load data.
// Misaligned, illegal (load and store both set) and timed-out accesses
// are reported on err/err_cause.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    // execute-stage interface
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    // data-memory interface
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // writeback / status
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // A zero timeout disables the abort entirely.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_load_q;
    logic [2:0]         funct3_q;
    logic [1:0]         byte_off_q;
    logic [4:0]         rd_q;

    logic               ex_ready_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [3:0]         mem_wstrb_q;
    logic [31:0]        mem_wdata_q;
    logic               wb_valid_q;
    logic [4:0]         wb_rd_q;
    logic [31:0]        wb_data_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         err_cause_q;

    logic               misaligned_d;
    logic [3:0]         wstrb_d;
    logic [31:0]        wdata_d;
    logic [7:0]         load_byte_d;
    logic [15:0]        load_half_d;
    logic [31:0]        load_data_d;

    // Alignment check and store lane steering from the incoming op.
    always_comb begin
        misaligned_d = 1'b0;
        wstrb_d      = 4'b1111;
        wdata_d      = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << ex_addr[1:0];
                wdata_d = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                misaligned_d = ex_addr[0];
                wstrb_d      = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d      = {2{ex_store_data[15:0]}};
            end
            2'b10: begin
                misaligned_d = (ex_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned_d = 1'b0;
            end
        endcase
    end

    // Select the addressed byte/half from the returned word and extend it.
    always_comb begin
        case (byte_off_q)
            2'd0:    load_byte_d = mem_rdata[7:0];
            2'd1:    load_byte_d = mem_rdata[15:8];
            2'd2:    load_byte_d = mem_rdata[23:16];
            default: load_byte_d = mem_rdata[31:24];
        endcase
        load_half_d = byte_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data_d = {{24{load_byte_d[7]}}, load_byte_d};
            3'b001:  load_data_d = {{16{load_half_d[15]}}, load_half_d};
            3'b100:  load_data_d = {24'd0, load_byte_d};
            3'b101:  load_data_d = {16'd0, load_half_d};
            default: load_data_d = mem_rdata;
        endcase
    end

    // Control FSM; every output is registered and pulses clear by default.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            byte_off_q  <= 2'd0;
            rd_q        <= 5'd0;
            ex_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= 2'd0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= 2'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && (ex_is_load || ex_is_store)) begin
                        ex_ready_q <= 1'b0;
                        is_load_q  <= ex_is_load;
                        funct3_q   <= ex_funct3;
                        byte_off_q <= ex_addr[1:0];
                        rd_q       <= ex_rd;
                        cnt_q      <= '0;
                        if (ex_is_load && ex_is_store) begin
                            state_q     <= S_ERR;
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_ILLEGAL;
                        end else if (misaligned_d) begin
                            state_q     <= S_ERR;
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_MISALIGN;
                        end else begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ex_is_store;
                            mem_addr_q  <= {ex_addr[31:2], 2'b00};
                            mem_wstrb_q <= ex_is_store ? wstrb_d : 4'd0;
                            mem_wdata_q <= ex_is_store ? wdata_d : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_q     <= S_DONE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_wstrb_q <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        done_q      <= 1'b1;
                        if (is_load_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_data_d;
                        end
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_q     <= S_ERR;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_wstrb_q <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        err_q       <= 1'b1;
                        err_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    ex_ready_q <= 1'b1;
                end
                S_ERR: begin
                    state_q    <= S_IDLE;
                    ex_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    ex_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ex_ready  = ex_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cause = err_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases followed by randomized ops,
// each compared against a small arithmetic model of the expected behaviour.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        err;
    logic [1:0]  err_cause;

    int checks = 0;
    int errors = 0;

    load_store_unit #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .done         (done),
        .err          (err),
        .err_cause    (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = 1 << (f3 % 4);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 32'd1 << (a % 4);
            3'd1:    return 32'd3 << (a & 32'd2);
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return (d & 32'hFF) * 32'h0101_0101;
            3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> ((a % 4) * 8)) & 32'hFF;
        h = (w >> ((a & 32'd2) * 8)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Drive one op from an IDLE negedge, play memory with the given ack
    // delay, check every cycle until the LSU is back in IDLE.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int delay);
        bit acked;
        chk("ready_idle", ex_ready, 1);
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_addr       = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        @(negedge clk);
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        if (!ld && !st) begin
            chk("ignored_ready", ex_ready, 1);
            chk("ignored_req", mem_req, 0);
            chk("ignored_err", err, 0);
            return;
        end
        if (ld && st) begin
            chk("illegal_err", err, 1);
            chk("illegal_cause", err_cause, 2'b11);
            chk("illegal_req", mem_req, 0);
        end else if (m_misaligned(f3, addr)) begin
            chk("misalign_err", err, 1);
            chk("misalign_cause", err_cause, 2'b01);
            chk("misalign_req", mem_req, 0);
        end else begin
            acked = 1'b0;
            for (int c = 0; c < TO; c++) begin
                chk("req", mem_req, 1);
                chk("req_we", mem_we, st);
                chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("req_wstrb", mem_wstrb, st ? m_wstrb(f3, addr) : 32'd0);
                chk("req_wdata", mem_wdata, st ? m_wdata(f3, sdata) : 32'd0);
                chk("req_done", done, 0);
                if (c == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (c == delay) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (acked) begin
                chk("done", done, 1);
                chk("done_err", err, 0);
                chk("done_req", mem_req, 0);
                chk("wb_valid", wb_valid, ld);
                chk("wb_rd", wb_rd, ld ? rd : 5'd0);
                chk("wb_data", wb_data, ld ? m_load(f3, addr, rdata) : 32'd0);
            end else begin
                chk("timeout_err", err, 1);
                chk("timeout_cause", err_cause, 2'b10);
                chk("timeout_req", mem_req, 0);
                chk("timeout_done", done, 0);
            end
        end
        @(negedge clk);
        chk("back_ready", ex_ready, 1);
        chk("back_done", done, 0);
        chk("back_err", err, 0);
        chk("back_cause", err_cause, 0);
        chk("back_wb_valid", wb_valid, 0);
        chk("back_wb_data", wb_data, 0);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] f3;
        int         kind;
        bit         ld, st;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // SW, immediate ack
        run_op(0, 1, 3'd2, 32'h104, 32'hDEAD_BEEF, 5'd0, 32'd0, 0);
        // LB / LBU / LH on a fixed word
        run_op(1, 0, 3'd0, 32'h203, 32'd0, 5'd7, 32'h80FF_0000, 1);
        chk("lb_const", wb_data, 0);
        run_op(1, 0, 3'd4, 32'h203, 32'd0, 5'd8, 32'h80FF_0000, 0);
        run_op(1, 0, 3'd1, 32'h202, 32'd0, 5'd9, 32'h80FF_0000, 2);
        // SB / SH lane steering
        run_op(0, 1, 3'd0, 32'h6, 32'h0000_00A5, 5'd0, 32'd0, 0);
        run_op(0, 1, 3'd1, 32'h6, 32'h1234_5678, 5'd0, 32'd0, 1);
        // misaligned
        run_op(1, 0, 3'd2, 32'h2, 32'd0, 5'd3, 32'd0, 0);
        run_op(1, 0, 3'd1, 32'h1, 32'd0, 5'd3, 32'd0, 0);
        // illegal and ignored ops
        run_op(1, 1, 3'd2, 32'h10, 32'd0, 5'd3, 32'd0, 0);
        run_op(0, 0, 3'd2, 32'h10, 32'd0, 5'd3, 32'd0, 0);
        // timeout: ack never arrives
        run_op(1, 0, 3'd2, 32'h300, 32'd0, 5'd4, 32'd0, 100);
        // rd=0 load still writes back
        run_op(1, 0, 3'd2, 32'h308, 32'd0, 5'd0, 32'h1357_9BDF, 3);

        // stray ack while idle is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_done", done, 0);
        chk("stray_req", mem_req, 0);
        chk("stray_ready", ex_ready, 1);

        // reset during REQ
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h40; ex_rd = 5'd5;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk("mid_req", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_ready", ex_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_wb", wb_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1, 0, 3'd2, 32'h44, 32'd0, 5'd6, 32'hCAFE_F00D, 1);

        // randomized ops
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            ld = (kind == 0) || (kind >= 2 && kind < 6);
            st = (kind == 0) || (kind >= 6);
            if (ld && !st) f3 = ld_f3[$urandom_range(0, 4)];
            else           f3 = 3'($urandom_range(0, 2));
            run_op(ld, st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom, int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
